// File: rtl/synth_bus_master.sv
// synth_bus_master
//   Initiator for the synth parameter bus. Host-side commands arrive over a
//   valid/ready handshake, are held in a command store, and are played out
//   one at a time as a three-phase bus cycle (SETUP, STROBE, HOLD), each
//   phase PHASE_CYCLES clocks long. Read data is sampled on the last HOLD
//   cycle and returned as a one-cycle RspValid pulse.
//
//   Build option: define SYNTH_BUS_CMD_FIFO_EN to use a 2**FIFO_AW deep
//   command FIFO. Without it, the store is a single holding register.
//
// Ports
//   Clock, Reset              system clock, synchronous active-high reset
//   CmdValid/CmdReady         command handshake
//   CmdWrite, CmdAddr, CmdData command fields (1 = write)
//   RspValid, RspData         read response (single-cycle pulse, data held)
//   Busy                      bus cycle in progress or commands queued
//   BusAddress, BusData       bus address, bidirectional bus data
//   BusReadWrite, BusClock    1 = write / 0 = read, bus strobe
module synth_bus_master #(
    parameter int PHASE_CYCLES = 2,
    parameter int FIFO_AW      = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic        CmdWrite,
    input  logic [15:0] CmdAddr,
    input  logic [7:0]  CmdData,
    output logic        RspValid,
    output logic [7:0]  RspData,
    output logic        Busy,
    output logic [15:0] BusAddress,
    inout  wire  [7:0]  BusData,
    output logic        BusReadWrite,
    output logic        BusClock
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [7:0]  phase;
    logic [7:0]  phase_next;
    logic        phase_last;

    logic        push;
    logic        pop;
    logic        store_empty;
    logic        store_full;
    logic        head_write;
    logic [15:0] head_addr;
    logic [7:0]  head_data;

    logic        drive_en;
    logic [7:0]  write_data;

    // Reset forces CmdReady low so nothing is accepted while it is asserted.
    assign CmdReady   = !store_full && !Reset;
    assign push       = CmdValid && CmdReady;
    assign Busy       = (state != ST_IDLE) || !store_empty;
    assign phase_last = (phase == PHASE_LAST);

    assign BusData = drive_en ? write_data : 8'bz;

`ifdef SYNTH_BUS_CMD_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [24:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    assign store_empty = (count == '0);
    assign store_full  = (count == (FIFO_AW + 1)'(DEPTH));
    assign {head_write, head_addr, head_data} = fifo_mem[rd_ptr];

    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {CmdWrite, CmdAddr, CmdData};
        end
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push && !pop) begin
                count <= count + (FIFO_AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (FIFO_AW + 1)'(1);
            end
        end
    end
`else
    localparam int unused_fifo_aw = FIFO_AW;

    logic        hold_valid;
    logic        hold_write;
    logic [15:0] hold_addr;
    logic [7:0]  hold_data;

    assign store_empty = !hold_valid;
    assign store_full  = hold_valid;
    assign head_write  = hold_write;
    assign head_addr   = hold_addr;
    assign head_data   = hold_data;

    // Push only happens while empty, pop only while full, so they never meet.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            hold_write <= CmdWrite;
            hold_addr  <= CmdAddr;
            hold_data  <= CmdData;
        end
    end
`endif

    // The end of HOLD pops straight into SETUP when work is waiting, so
    // back-to-back commands run without an IDLE gap.
    always_comb begin
        state_next = state;
        phase_next = phase;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!store_empty) begin
                    pop        = 1'b1;
                    state_next = ST_SETUP;
                    phase_next = '0;
                end
            end
            ST_SETUP: begin
                if (phase_last) begin
                    state_next = ST_STROBE;
                    phase_next = '0;
                end else begin
                    phase_next = phase + 8'd1;
                end
            end
            ST_STROBE: begin
                if (phase_last) begin
                    state_next = ST_HOLD;
                    phase_next = '0;
                end else begin
                    phase_next = phase + 8'd1;
                end
            end
            default: begin
                if (phase_last) begin
                    phase_next = '0;
                    if (!store_empty) begin
                        pop        = 1'b1;
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    phase_next = phase + 8'd1;
                end
            end
        endcase
    end

    // Bus outputs are registered from the next state so BusClock is glitch-free.
    // Read data is captured before the write driver of a following command turns on.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_IDLE;
            phase        <= '0;
            BusClock     <= 1'b0;
            BusReadWrite <= 1'b1;
            BusAddress   <= '0;
            drive_en     <= 1'b0;
            write_data   <= '0;
            RspValid     <= 1'b0;
            RspData      <= '0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            BusClock <= (state_next == ST_STROBE);
            RspValid <= 1'b0;
            if (state == ST_HOLD && phase_last && !BusReadWrite) begin
                RspData  <= BusData;
                RspValid <= 1'b1;
            end
            if (pop) begin
                BusAddress   <= head_addr;
                BusReadWrite <= head_write;
                write_data   <= head_data;
                drive_en     <= head_write;
            end else if (state_next == ST_IDLE) begin
                BusReadWrite <= 1'b1;
                drive_en     <= 1'b0;
            end
        end
    end

endmodule
